mem_loader: RTL and testbench
=============================

# mem_loader

Boot-time memory loader that writes a program or data image into a single-port `sram` instance before the processor runs. It accepts a framed byte stream on a valid/ready handshake, assembles 16-bit words MSB-first, and writes them to consecutive SRAM addresses. It holds the processor's `reset` high until the whole frame has been written. It sits between an external byte source (UART receiver, debug port, bench driver) and the SRAM `WE`/`A`/`Din` pins, in place of the file-based preload.

## Interface
- `ADDR_WIDTH`, 16, SRAM address width; word width is fixed at 16.
- `clk`  in  1  system clock; all logic on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `in_data`  in  8  stream byte.
- `in_valid`  in  1  `in_data` is valid.
- `in_ready`  out  1  loader accepts the byte; transfer occurs when `in_valid & in_ready` at a rising edge.
- `mem_write`  out  1  drives SRAM `WE`.
- `mem_addr`  out  ADDR_WIDTH  drives SRAM `A`.
- `mem_in`  out  16  drives SRAM `Din`.
- `cpu_reset`  out  1  drives processor `reset`; high until load completes.
- `done`  out  1  frame fully written; sticky.
- `error`  out  1  checksum mismatch; sticky. Tied 0 without the checksum feature.

## Operation
- Frame format, all fields MSB first: ADDR_HI, ADDR_LO (start address S); CNT_HI, CNT_LO (word count N, 0..65535); then 2N data bytes; then CSUM_HI, CSUM_LO when checksum is enabled.
- States: HDR_A_HI → HDR_A_LO → HDR_N_HI → HDR_N_LO → DATA_HI ⇄ DATA_LO → [CSUM_HI → CSUM_LO] → DONE | ERROR.
- Each state advances only on an accepted byte. There is no timeout, and `in_valid` low simply stalls the loader.
- At HDR_N_LO, if N=0 the FSM goes to CSUM_HI (checksum enabled) or DONE.
- DATA_HI latches the high byte. DATA_LO forms the word {hi,lo}, issues the write, and increments the address and the words-written count. After word N the FSM exits to CSUM_HI or DONE.
- Address arithmetic is modulo 2^ADDR_WIDTH: S=0xFFFF with N=2 writes 0xFFFF then 0x0000.
- `in_ready` is 1 in every receive state and 0 in reset, DONE and ERROR. Bytes offered in DONE are ignored.
- Reset at any point, including mid-frame, aborts the load. The loader returns to HDR_A_HI with reset output values and does not complete any partial word.

## Timing
- Reset values: `in_ready`=0, `mem_write`=0, `mem_addr`=0, `mem_in`=0, `cpu_reset`=1, `done`=0, `error`=0. `in_ready` rises on the first edge after `reset` deasserts.
- All outputs are registered.
- Word write: on the edge that accepts the DATA_LO byte, `mem_write`=1, `mem_addr`=S+k and `mem_in`=word are registered. They are held for exactly one cycle, so the SRAM captures the word on the following edge. `mem_write` returns to 0 unless the next word's low byte is accepted on that same edge.
- Sustained throughput is 1 byte per cycle, i.e. 1 word per 2 cycles. Back-to-back writes are never adjacent.
- Completion: `done`=1 and `cpu_reset`=0 are registered on the edge after the final SRAM write edge. That is 2 edges after the last data byte is accepted, or 1 edge after CNT_LO/CSUM_LO is accepted when N=0. The processor therefore never fetches before the image is in memory.
- `done` and `cpu_reset`=0 persist until `reset`.

## Configuration
- `MEM_LOADER_CHECKSUM_EN` defined:
  - The frame carries a trailing 16-bit checksum, equal to the sum mod 2^16 of all N data words.
  - On match the FSM goes to DONE with the timing above.
  - On mismatch the FSM goes to ERROR: `error`=1 one edge after CSUM_LO is accepted, `cpu_reset` stays 1, `done` stays 0, `in_ready`=0.
  - Words already written remain in SRAM.
- Not defined:
  - No checksum states exist and `error` is constant 0.
  - The FSM exits DATA_LO or HDR_N_LO directly to DONE.

## Test plan
- Frame S=0x0010, N=3, words 0x1234, 0xABCD, 0x0001, streamed continuously → SRAM[0x10..0x12]=1234, ABCD, 0001. Three one-cycle `mem_write` pulses spaced 2 cycles apart. `cpu_reset` falls 2 edges after the last byte.
- Same frame with `in_valid` toggled randomly → identical SRAM contents. No write occurs while stalled.
- S=0xFFFF, N=2, words 0xAAAA, 0x5555 → SRAM[0xFFFF]=AAAA, SRAM[0x0000]=5555.
- N=0 → no `mem_write`. `done`=1 and `cpu_reset`=0 one edge after CNT_LO (or CSUM_LO with checksum 0x0000). Bytes offered afterwards see `in_ready`=0.
- `reset` pulsed after the DATA_HI byte of word 2 of a 4-word frame → outputs return to reset values and SRAM is unchanged beyond word 1. A fresh full frame then loads correctly.
- With `MEM_LOADER_CHECKSUM_EN`:
  - Words 0x8000, 0x8001 with checksum 0x0001 → `done`=1.
  - The same words with checksum 0x0002 → `error`=1, `cpu_reset` held 1.

Source files
------------

// File: rtl/mem_loader.sv
// -----------------------------------------------------------------------------
// mem_loader
//
// Boot-time loader that copies a framed byte stream into a single-port SRAM
// and holds the processor in reset until the image is completely written.
//
// Frame (all fields MSB first):
//   ADDR_HI, ADDR_LO      start address S
//   CNT_HI,  CNT_LO       word count N (0..65535)
//   2*N data bytes        words assembled {hi, lo}, written to S, S+1, ...
//   CSUM_HI, CSUM_LO      only with MEM_LOADER_CHECKSUM_EN: sum mod 2^16 of
//                         all N data words
//
// Optional feature macro: MEM_LOADER_CHECKSUM_EN
//   defined   : trailing checksum is checked; a mismatch parks the loader in
//               ERROR with cpu_reset held high and error set.
//   undefined : no checksum states, error is constant 0.
//
// Handshake: a byte transfers on a rising edge where in_valid and in_ready
// are both 1. in_valid may drop at any time (stall); in_ready is 1 in every
// receive state and 0 during reset, after completion and after an error.
//
// Ports:
//   clk        system clock, rising edge
//   reset      synchronous active-high reset; aborts any load in progress
//   in_data    stream byte
//   in_valid   in_data is valid
//   in_ready   loader can accept a byte this cycle
//   mem_write  SRAM WE, one-cycle pulse per word
//   mem_addr   SRAM A
//   mem_in     SRAM Din
//   cpu_reset  processor reset, high until the load completes
//   done       frame fully written (sticky until reset)
//   error      checksum mismatch (sticky until reset)
//   dbg_state  current FSM state encoding, for observation only
//
// All outputs are registered.
// -----------------------------------------------------------------------------
module mem_loader #(
    parameter int ADDR_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [7:0]            in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic                  mem_write,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [15:0]           mem_in,
    output logic                  cpu_reset,
    output logic                  done,
    output logic                  error,
    output logic [3:0]            dbg_state
);

    typedef enum logic [3:0] {
        HDR_A_HI = 4'd0,
        HDR_A_LO = 4'd1,
        HDR_N_HI = 4'd2,
        HDR_N_LO = 4'd3,
        DATA_HI  = 4'd4,
        DATA_LO  = 4'd5,
        // One idle cycle after the final write so that done/cpu_reset change
        // only after the SRAM has captured the last word.
        FLUSH    = 4'd6,
        DONE     = 4'd7
`ifdef MEM_LOADER_CHECKSUM_EN
        ,
        CSUM_HI  = 4'd8,
        CSUM_LO  = 4'd9,
        ERROR    = 4'd10
`endif
    } state_t;

    state_t                  state, state_d;
    logic [7:0]              hi_q, hi_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [15:0]             left_q, left_d;
`ifdef MEM_LOADER_CHECKSUM_EN
    logic [15:0]             csum_q, csum_d;
`endif

    logic                    in_ready_d;
    logic                    mem_write_d;
    logic [ADDR_WIDTH-1:0]   mem_addr_d;
    logic [15:0]             mem_in_d;
    logic                    cpu_reset_d;
    logic                    done_d;
    logic                    error_d;

    logic                    accept;
    logic [15:0]             word;

    assign accept    = in_valid & in_ready;
    // Every 16-bit field is the held high byte joined with the current byte.
    assign word      = {hi_q, in_data};
    assign dbg_state = state;

    // -------------------------------------------------------------------------
    // Next-state and next-output logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d     = state;
        hi_d        = hi_q;
        addr_d      = addr_q;
        left_d      = left_q;
`ifdef MEM_LOADER_CHECKSUM_EN
        csum_d      = csum_q;
`endif
        mem_write_d = 1'b0;
        mem_addr_d  = mem_addr;
        mem_in_d    = mem_in;

        case (state)
            HDR_A_HI: begin
                if (accept) begin
                    hi_d    = in_data;
                    state_d = HDR_A_LO;
                end
            end
            HDR_A_LO: begin
                if (accept) begin
                    addr_d  = ADDR_WIDTH'(word);
                    state_d = HDR_N_HI;
                end
            end
            HDR_N_HI: begin
                if (accept) begin
                    hi_d    = in_data;
                    state_d = HDR_N_LO;
                end
            end
            HDR_N_LO: begin
                if (accept) begin
                    left_d = word;
`ifdef MEM_LOADER_CHECKSUM_EN
                    csum_d = 16'h0000;
`endif
                    if (word == 16'h0000) begin
                        // Nothing to write, so no flush cycle is needed.
`ifdef MEM_LOADER_CHECKSUM_EN
                        state_d = CSUM_HI;
`else
                        state_d = DONE;
`endif
                    end else begin
                        state_d = DATA_HI;
                    end
                end
            end
            DATA_HI: begin
                if (accept) begin
                    hi_d    = in_data;
                    state_d = DATA_LO;
                end
            end
            DATA_LO: begin
                if (accept) begin
                    mem_write_d = 1'b1;
                    mem_addr_d  = addr_q;
                    mem_in_d    = word;
                    addr_d      = addr_q + 1'b1;   // wraps modulo 2^ADDR_WIDTH
                    left_d      = left_q - 16'd1;
`ifdef MEM_LOADER_CHECKSUM_EN
                    csum_d      = csum_q + word;
`endif
                    if (left_q == 16'd1) begin
`ifdef MEM_LOADER_CHECKSUM_EN
                        // The two checksum bytes take at least two cycles,
                        // which covers the SRAM capture of the last word.
                        state_d = CSUM_HI;
`else
                        state_d = FLUSH;
`endif
                    end else begin
                        state_d = DATA_HI;
                    end
                end
            end
            FLUSH: begin
                state_d = DONE;
            end
            DONE: begin
                state_d = DONE;
            end
`ifdef MEM_LOADER_CHECKSUM_EN
            CSUM_HI: begin
                if (accept) begin
                    hi_d    = in_data;
                    state_d = CSUM_LO;
                end
            end
            CSUM_LO: begin
                if (accept) begin
                    state_d = (word == csum_q) ? DONE : ERROR;
                end
            end
            ERROR: begin
                state_d = ERROR;
            end
`endif
            default: begin
                state_d = HDR_A_HI;
            end
        endcase

        // in_ready is registered from the state we are about to enter, so it
        // is already low on the cycle the loader reaches FLUSH/DONE/ERROR.
        in_ready_d = 1'b0;
        case (state_d)
            HDR_A_HI, HDR_A_LO, HDR_N_HI, HDR_N_LO, DATA_HI, DATA_LO:
                in_ready_d = 1'b1;
`ifdef MEM_LOADER_CHECKSUM_EN
            CSUM_HI, CSUM_LO:
                in_ready_d = 1'b1;
`endif
            default:
                in_ready_d = 1'b0;
        endcase

        // Completion flags follow the registered state, one edge after the
        // FSM has entered DONE (or ERROR).
        done_d      = (state == DONE);
        cpu_reset_d = (state != DONE);
`ifdef MEM_LOADER_CHECKSUM_EN
        error_d     = (state == ERROR);
`else
        error_d     = 1'b0;
`endif
    end

    // -------------------------------------------------------------------------
    // State and output registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= HDR_A_HI;
            hi_q      <= 8'h00;
            addr_q    <= '0;
            left_q    <= 16'h0000;
`ifdef MEM_LOADER_CHECKSUM_EN
            csum_q    <= 16'h0000;
`endif
            in_ready  <= 1'b0;
            mem_write <= 1'b0;
            mem_addr  <= '0;
            mem_in    <= 16'h0000;
            cpu_reset <= 1'b1;
            done      <= 1'b0;
            error     <= 1'b0;
        end else begin
            state     <= state_d;
            hi_q      <= hi_d;
            addr_q    <= addr_d;
            left_q    <= left_d;
`ifdef MEM_LOADER_CHECKSUM_EN
            csum_q    <= csum_d;
`endif
            in_ready  <= in_ready_d;
            mem_write <= mem_write_d;
            mem_addr  <= mem_addr_d;
            mem_in    <= mem_in_d;
            cpu_reset <= cpu_reset_d;
            done      <= done_d;
            error     <= error_d;
        end
    end

endmodule

// File: tb/tb_mem_loader.sv
// -----------------------------------------------------------------------------
// tb_mem_loader
//
// Directed frames against mem_loader. A small frame model parses the accepted
// byte stream to decide on which cycles a write must appear; the frame builder
// fills an expected-write queue and an expected memory image; a compare
// process checks outputs every cycle and keeps an SRAM image from the DUT's
// write port.
// -----------------------------------------------------------------------------
module tb_mem_loader;

`ifdef MEM_LOADER_CHECKSUM_EN
    localparam bit CSUM_ON = 1'b1;
`else
    localparam bit CSUM_ON = 1'b0;
`endif

    // ---------------- clock / reset ----------------
    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic        mem_write;
    logic [15:0] mem_addr;
    logic [15:0] mem_in;
    logic        cpu_reset;
    logic        done;
    logic        error;
    logic [3:0]  dbg_state;

    always #5 clk = ~clk;

    mem_loader #(.ADDR_WIDTH(16)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .mem_write (mem_write),
        .mem_addr  (mem_addr),
        .mem_in    (mem_in),
        .cpu_reset (cpu_reset),
        .done      (done),
        .error     (error),
        .dbg_state (dbg_state)
    );

    // ---------------- scoreboard state ----------------
    int          total = 0;
    int          bad   = 0;
    logic [31:0] exp_q[$];          // {addr, data} of each expected write
    logic [15:0] sram[int];         // image captured from the write port
    logic [15:0] exp_mem[int];      // image the frames should produce
    int          wr_cyc[$];         // cycle index of each observed write
    logic [15:0] words[8];

    // frame model state
    int          pos;
    int          n_m;
    int          d_m;
    logic [7:0]  hdr[4];
    bit          wr_due;
    bit          prev_wr;
    int          negc = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Frame model: every accepted odd data byte completes a word, which must
    // show up as a write on the following cycle.
    always @(posedge clk) begin
        if (reset) begin
            pos    = 0;
            wr_due = 1'b0;
        end else if (in_valid && in_ready) begin
            if (pos < 4) hdr[pos] = in_data;
            if (pos == 3) begin
                n_m = int'({hdr[2], in_data});
            end else if (pos >= 4) begin
                d_m = pos - 4;
                if (d_m < 2 * n_m && (d_m % 2) == 1) wr_due = 1'b1;
            end
            pos++;
        end
    end

    // Compare process, sampled on the falling edge.
    always @(negedge clk) begin
        negc++;
        if (!reset) begin
            chk("mem_write_timing", {31'd0, mem_write}, {31'd0, wr_due});
            if (mem_write) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_write", {mem_addr, mem_in}, 32'hxxxx_xxxx);
                end else begin
                    chk("write_addr_data", {mem_addr, mem_in}, exp_q.pop_front());
                end
                sram[int'(mem_addr)] = mem_in;
                wr_cyc.push_back(negc);
                if (prev_wr) chk("adjacent_writes", 32'd1, 32'd0);
            end
            chk("cpu_reset_vs_done", {31'd0, cpu_reset}, {31'd0, ~done});
            if (done || error) chk("ready_after_end", {31'd0, in_ready}, 32'd0);
        end
        wr_due  = 1'b0;
        prev_wr = mem_write;
    end

    // ---------------- driver tasks ----------------
    // Called at a falling edge; returns at the falling edge after acceptance.
    task automatic send_byte(input logic [7:0] b, input bit rnd);
        int n;
        if (rnd) begin
            in_valid = 1'b0;
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end
        in_data  = b;
        in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            chk("ready_timeout", {31'd0, in_ready}, 32'd1);
            return;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset    = 1'b1;
        in_valid = 1'b0;
        in_data  = 8'h00;
        @(negedge clk);
        @(negedge clk);
        chk("rst_in_ready",  {31'd0, in_ready},  32'd0);
        chk("rst_mem_write", {31'd0, mem_write}, 32'd0);
        chk("rst_mem_addr",  {16'd0, mem_addr},  32'd0);
        chk("rst_mem_in",    {16'd0, mem_in},    32'd0);
        chk("rst_cpu_reset", {31'd0, cpu_reset}, 32'd1);
        chk("rst_done",      {31'd0, done},      32'd0);
        chk("rst_error",     {31'd0, error},     32'd0);
        exp_q.delete();
        reset = 1'b0;
        @(negedge clk);
        chk("ready_after_rst", {31'd0, in_ready}, 32'd1);
    endtask

    // Builds and sends one frame. cut >= 0 stops after that many bytes.
    task automatic frame(input logic [15:0] s, input int n, input bit rnd,
                         input bit bad_csum, input int cut);
        logic [7:0]  bytes[$];
        logic [15:0] sum;
        logic [15:0] c;
        logic [15:0] n16;
        int          limit;
        int          lat;
        sum = 16'h0000;
        n16 = 16'(n);
        bytes.delete();
        bytes.push_back(s[15:8]);
        bytes.push_back(s[7:0]);
        bytes.push_back(n16[15:8]);
        bytes.push_back(n16[7:0]);
        for (int k = 0; k < n; k++) begin
            bytes.push_back(words[k][15:8]);
            bytes.push_back(words[k][7:0]);
            sum = sum + words[k];
        end
        if (CSUM_ON) begin
            c = bad_csum ? sum + 16'd1 : sum;
            bytes.push_back(c[15:8]);
            bytes.push_back(c[7:0]);
        end
        limit = (cut >= 0) ? cut : bytes.size();
        for (int k = 0; k < n; k++) begin
            if (4 + 2 * k + 1 < limit) begin
                exp_q.push_back({16'(s + k), words[k]});
                exp_mem[int'(16'(s + k))] = words[k];
            end
        end
        for (int i = 0; i < limit; i++) send_byte(bytes[i], rnd);
        in_valid = 1'b0;
        if (cut >= 0) return;

        lat = (CSUM_ON || n == 0) ? 1 : 2;
        chk("done_early", {31'd0, done}, 32'd0);
        for (int i = 1; i < lat; i++) begin
            @(negedge clk);
            chk("done_early", {31'd0, done}, 32'd0);
        end
        @(negedge clk);
        if (bad_csum) begin
            chk("csum_error",     {31'd0, error},     32'd1);
            chk("csum_cpu_reset", {31'd0, cpu_reset}, 32'd1);
            chk("csum_done",      {31'd0, done},      32'd0);
            chk("csum_in_ready",  {31'd0, in_ready},  32'd0);
        end else begin
            chk("done_set",      {31'd0, done},      32'd1);
            chk("cpu_reset_low", {31'd0, cpu_reset}, 32'd0);
            chk("error_clear",   {31'd0, error},     32'd0);
        end
        chk("exp_q_drained", exp_q.size(), 32'd0);
        for (int k = 0; k < n; k++) begin
            chk("sram_vs_model", {16'd0, sram.exists(int'(16'(s + k))) ? sram[int'(16'(s + k))] : 16'hDEAD},
                {16'd0, exp_mem[int'(16'(s + k))]});
        end
    endtask

    task automatic offer_after_end();
        in_data  = 8'h5A;
        in_valid = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("ignored_in_ready", {31'd0, in_ready}, 32'd0);
        end
        in_valid = 1'b0;
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #2000000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    // ---------------- directed sequence ----------------
    initial begin
        reset    = 1'b1;
        in_valid = 1'b0;
        in_data  = 8'h00;
        @(negedge clk);

        // 1: continuous three-word frame at 0x0010
        do_reset();
        words[0] = 16'h1234; words[1] = 16'hABCD; words[2] = 16'h0001;
        wr_cyc.delete();
        frame(16'h0010, 3, 1'b0, 1'b0, -1);
        chk("lit_sram_10", {16'd0, sram[16'h0010]}, 32'h1234);
        chk("lit_sram_11", {16'd0, sram[16'h0011]}, 32'hABCD);
        chk("lit_sram_12", {16'd0, sram[16'h0012]}, 32'h0001);
        chk("write_count", wr_cyc.size(), 32'd3);
        if (wr_cyc.size() == 3) begin
            chk("write_gap_1", wr_cyc[1] - wr_cyc[0], 32'd2);
            chk("write_gap_2", wr_cyc[2] - wr_cyc[1], 32'd2);
        end
        offer_after_end();

        // 2: same frame with random stalls
        do_reset();
        frame(16'h0010, 3, 1'b1, 1'b0, -1);
        chk("lit_stall_11", {16'd0, sram[16'h0011]}, 32'hABCD);

        // 3: address wrap
        do_reset();
        words[0] = 16'hAAAA; words[1] = 16'h5555;
        frame(16'hFFFF, 2, 1'b0, 1'b0, -1);
        chk("lit_wrap_ffff", {16'd0, sram[16'hFFFF]}, 32'hAAAA);
        chk("lit_wrap_0000", {16'd0, sram[16'h0000]}, 32'h5555);

        // 4: empty frame
        do_reset();
        frame(16'h0200, 0, 1'b0, 1'b0, -1);
        offer_after_end();

        // 5: reset after the high byte of word 2, then a full reload
        do_reset();
        words[0] = 16'h1111; words[1] = 16'h2222;
        words[2] = 16'h3333; words[3] = 16'h4444;
        frame(16'h0100, 4, 1'b0, 1'b0, 7);
        do_reset();
        chk("abort_word1_kept", {16'd0, sram[16'h0100]}, 32'h1111);
        chk("abort_word2_none", {31'd0, sram.exists(16'h0101)}, 32'd0);
        chk("abort_word3_none", {31'd0, sram.exists(16'h0102)}, 32'd0);
        frame(16'h0100, 4, 1'b1, 1'b0, -1);
        chk("lit_reload_103", {16'd0, sram[16'h0103]}, 32'h4444);

`ifdef MEM_LOADER_CHECKSUM_EN
        // 6: checksum match and mismatch
        do_reset();
        words[0] = 16'h8000; words[1] = 16'h8001;
        frame(16'h0300, 2, 1'b0, 1'b0, -1);
        do_reset();
        frame(16'h0310, 2, 1'b0, 1'b1, -1);
        offer_after_end();
        chk("csum_words_kept", {16'd0, sram[16'h0311]}, 32'h8001);
`endif

        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
